ln_taylor_seq: RTL and testbench

- Sequential fixed-point natural logarithm: the inverse companion to the team's combinational Taylor-series exponential block, using the same signed Q(INT_WIDTH).(FRAC_WIDTH) format.
- Works by range reduction (x = m·2^k) followed by one Taylor term of ln(1+y) per clock.
- Start/busy/done handshake, so it can sit behind a register-mapped math unit or a softmax/log-likelihood datapath.

---
 rtl/ln_taylor_seq.sv | 143 ++++++++++++++
 tb/tb_ln_taylor_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ln_taylor_seq.sv
// Sequential fixed-point natural log: normalise x = m*2^k, then accumulate one
// ln(1+y) Taylor term per clock. Same signed Q(INT).(FRAC) format as the exp block.
module ln_taylor_seq #(
   parameter int INT_WIDTH  = 8,
   parameter int FRAC_WIDTH = 8,
   parameter int TERMS      = 8,
   parameter int GUARD      = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] x,
   output logic                                   busy,
   output logic                                   done,
   output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] result,
   output logic                                   err
);
   localparam int TW = INT_WIDTH + FRAC_WIDTH;
   localparam int W  = TW + GUARD + 4;
   localparam int FP = FRAC_WIDTH + GUARD;

   localparam logic signed [W-1:0]  ONE    = W'(1) << FP;
   localparam logic signed [W-1:0]  HALF   = W'(1) << (GUARD - 1);
   localparam logic signed [W-1:0]  LN2    = W'($rtoi(0.6931471805599453 * (2.0 ** FP) + 0.5));
   localparam logic signed [W-1:0]  OMAX   = W'((64'sd1 <<< (TW - 1)) - 64'sd1);
   localparam logic signed [W-1:0]  OMIN   = ~OMAX;
   localparam logic signed [TW-1:0] SAT_HI = {1'b0, {(TW-1){1'b1}}};
   localparam logic signed [TW-1:0] SAT_LO = {1'b1, {(TW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_NORM, S_SERIES, S_DONE} state_t;

   state_t                r_state, w_next;
   logic signed [TW-1:0]  r_x;
   logic signed [W-1:0]   r_pow, r_y, r_sum;
   logic [3:0]            r_n;
   logic signed [TW-1:0]  r_result;
   logic                  r_err;

   // 1/n table, rounded to F' fractional bits, so the series needs no divider
   logic signed [W-1:0] w_recip [0:15];
   for (genvar g = 0; g < 16; g++) begin : g_recip
      if (g == 0) begin : g_zero
         assign w_recip[g] = '0;
      end else begin : g_val
         assign w_recip[g] = W'(((64'd1 << FP) + 64'(g / 2)) / 64'(g));
      end
   end

   int                  w_p;
   logic signed [W-1:0] w_m0, w_m, w_k, w_y0;
   logic                w_half, w_nonpos;

   // m0 in [1,2); folding m0 >= 1.5 down to m0/2 keeps y within [-0.25, 0.5)
   always_comb begin
      w_p = 0;
      for (int i = 0; i < TW - 1; i++)
         if (r_x[i]) w_p = i;
      w_m0   = W'(r_x) << (FP - w_p);
      w_half = w_m0[FP-1];
      w_m    = w_half ? (w_m0 >>> 1) : w_m0;
      w_k    = W'(w_p - FRAC_WIDTH + (w_half ? 1 : 0));
      w_y0   = w_m - ONE;
   end

   assign w_nonpos = r_x[TW-1] | (r_x == '0);

   logic signed [2*W-1:0] w_tprod, w_pprod;
   logic signed [W-1:0]   w_term, w_sum_nxt, w_pow_nxt, w_rnd;
   logic signed [TW-1:0]  w_res;
   logic                  w_unused;

   assign w_tprod   = (2*W)'(r_pow) * (2*W)'(w_recip[r_n]);
   assign w_pprod   = (2*W)'(r_pow) * (2*W)'(r_y);
   assign w_term    = w_tprod[FP +: W];
   assign w_pow_nxt = w_pprod[FP +: W];
   assign w_sum_nxt = r_n[0] ? (r_sum + w_term) : (r_sum - w_term);
   assign w_rnd     = (w_sum_nxt + HALF) >>> GUARD;
   assign w_res     = (w_rnd > OMAX) ? SAT_HI :
                      (w_rnd < OMIN) ? SAT_LO : w_rnd[TW-1:0];
   assign w_unused  = ^{w_tprod[FP-1:0], w_tprod[2*W-1:FP+W],
                        w_pprod[FP-1:0], w_pprod[2*W-1:FP+W]};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_NORM;
         S_NORM:   w_next = w_nonpos ? S_DONE : S_SERIES;
         S_SERIES: if (r_n == 4'(TERMS)) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_NORM) || (r_state == S_SERIES);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x      <= '0;
         r_pow    <= '0;
         r_y      <= '0;
         r_sum    <= '0;
         r_n      <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) r_x <= x;
            S_NORM: begin
               if (w_nonpos) begin
                  r_result <= SAT_LO;
                  r_err    <= 1'b1;
               end else begin
                  r_pow <= w_y0;
                  r_y   <= w_y0;
                  r_sum <= w_k * LN2;
                  r_n   <= 4'd1;
               end
            end
            S_SERIES: begin
               r_sum <= w_sum_nxt;
               r_pow <= w_pow_nxt;
               r_n   <= r_n + 4'd1;
               if (r_n == 4'(TERMS)) begin
                  r_result <= w_res;
                  r_err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;
   assign err    = r_err;
endmodule

// File: tb/tb_ln_taylor_seq.sv
// Bench for ln_taylor_seq: cycle-level handshake model plus real-valued ln reference.
module tb_ln_taylor_seq;
   localparam int TERMS = 8;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] x;
   logic        busy, done, err;
   logic [15:0] result;

   ln_taylor_seq dut (
      .clk(clk), .rst(rst), .start(start), .x(x),
      .busy(busy), .done(done), .result(result), .err(err)
   );

   always #5 clk = ~clk;

   function automatic int ref_ln(input logic [15:0] xv);
      real r;
      r = $itor($signed(xv)) / 256.0;
      return $rtoi($floor($ln(r) * 256.0 + 0.5));
   endfunction

   // model state (written only by the model process)
   int          cyc = 0;
   int          m_acc = -100, m_done = -100;
   logic [15:0] m_x = '0;
   int          h_exp = 0, h_tol = 0;
   logic        h_err = 1'b0;

   // directives from the stimulus process
   logic        lit_on = 1'b0;
   int          lit_res = 0, lit_tol = 0, lit_lat = 0, lit_busy = 0, lit_gap = 0;
   logic        lit_err = 1'b0;
   string       lit_nm = "none";

   int          checks = 0, fails = 0;

   // Idle in cycle c when c > done cycle; accepted start gives done at +2 (x<=0) or +TERMS+2.
   always @(posedge clk) begin
      if (rst) begin
         m_acc  = -100;
         m_done = -100;
         h_exp  = 0;
         h_tol  = 0;
         h_err  = 1'b0;
      end else if (cyc > m_done && start) begin
         m_acc  = cyc;
         m_x    = x;
         m_done = cyc + (($signed(m_x) <= 0) ? 2 : TERMS + 2);
      end
      cyc++;
      if (cyc == m_done) begin
         if ($signed(m_x) <= 0) begin
            h_exp = -32768; h_tol = 0; h_err = 1'b1;
         end else begin
            h_exp = ref_ln(m_x); h_tol = 1; h_err = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp, input int tol);
      int d;
      checks++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", nm, act, exp, tol, cyc);
      end
   endtask

   int   busy_run = 0;
   int   gap_last = -1;
   logic e_busy, e_done;

   always @(negedge clk) begin
      if (cyc == 1) begin
         chk("model_ln2",  ref_ln(16'h0200), 177, 0);
         chk("model_e",    ref_ln(16'h02B8), 256, 0);
         chk("model_half", ref_ln(16'h0080), -177, 0);
         chk("model_min",  ref_ln(16'h0001), -1420, 0);
         chk("model_max",  ref_ln(16'h7FFF), 1242, 0);
      end
      if (cyc >= 1) begin
         e_busy = (cyc > m_acc) && (cyc < m_done);
         e_done = (cyc == m_done);
         chk("busy",   int'(busy), int'(e_busy), 0);
         chk("done",   int'(done), int'(e_done), 0);
         chk("err",    int'(err), int'(h_err), 0);
         chk("result", int'($signed(result)), h_exp, h_tol);
         if (cyc == m_acc + 1) busy_run = 0;
         if (busy) busy_run++;
         if (e_done && lit_on) begin
            chk($sformatf("%s_res", lit_nm),  int'($signed(result)), lit_res, lit_tol);
            chk($sformatf("%s_err", lit_nm),  int'(err), int'(lit_err), 0);
            chk($sformatf("%s_lat", lit_nm),  cyc - m_acc, lit_lat, 0);
            chk($sformatf("%s_busy", lit_nm), busy_run, lit_busy, 0);
         end
         if (done) begin
            if (lit_gap > 0 && gap_last > 0) chk("held_gap", cyc - gap_last, lit_gap, 0);
            gap_last = (lit_gap > 0) ? cyc : -1;
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 60 && cyc <= m_done; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic op(input logic [15:0] xv, input int r, input int tol, input logic e,
                     input int lat, input int bc, input string nm);
      lit_res = r; lit_tol = tol; lit_err = e; lit_lat = lat; lit_busy = bc; lit_nm = nm;
      lit_on = 1'b1;
      x = xv;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
   endtask

   initial begin
      logic [15:0] xv;
      int          v;
      rst = 1'b1; start = 1'b0; x = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      op(16'h0100, 0,     0, 1'b0, 10, 9, "one");
      op(16'h0200, 177,   1, 1'b0, 10, 9, "two");
      op(16'h02B8, 256,   1, 1'b0, 10, 9, "e");
      op(16'h0080, -177,  1, 1'b0, 10, 9, "half");
      op(16'h0001, -1420, 1, 1'b0, 10, 9, "min");
      op(16'h7FFF, 1242,  1, 1'b0, 10, 9, "max");
      op(16'h017F, 103,   1, 1'b0, 10, 9, "below1p5");
      op(16'h0180, 104,   1, 1'b0, 10, 9, "at1p5");
      op(16'h0000, -32768, 0, 1'b1, 2, 1, "zero");
      op(16'hFF00, -32768, 0, 1'b1, 2, 1, "neg1");
      op(16'h0100, 0,     0, 1'b0, 10, 9, "clr_err");
      op(16'h8000, -32768, 0, 1'b1, 2, 1, "mostneg");

      // start held high: one operation every TERMS+3 cycles
      lit_on = 1'b0;
      lit_gap = TERMS + 3;
      x = 16'h0200;
      start = 1'b1;
      repeat (45) begin @(posedge clk); #1; end
      start = 1'b0;
      wait_idle();
      lit_gap = 0;

      // reset during the third SERIES cycle aborts the operation
      x = 16'h0200;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      op(16'h0200, 177, 1, 1'b0, 10, 9, "after_rst");

      for (int i = 0; i < 2200; i++) begin
         if (i % 11 == 10) begin
            v  = int'($urandom_range(0, 32768));
            xv = 16'(-v);
            op(xv, -32768, 0, 1'b1, 2, 1, "rnd_err");
         end else begin
            xv = 16'($urandom_range(1, 32767));
            op(xv, ref_ln(xv), 1, 1'b0, 10, 9, "rnd");
         end
      end

      lit_on = 1'b0;
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
